// File: rtl/ttt_match_controller.sv
// Turn arbiter, move filter and best-of-N scorekeeper in front of the tic-tac-toe engine.
// Define TTT_TURN_TIMEOUT_EN to build the turn timer that auto-plays for a stalled player.
module ttt_match_controller #(
    parameter int TURN_TIMEOUT  = 1000,
    parameter int ROUNDS_TO_WIN = 3,
    parameter int SCORE_W       = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               x_req,
    input  logic [3:0]         x_pos,
    output logic               x_ack,
    input  logic               o_req,
    input  logic [3:0]         o_pos,
    output logic               o_ack,
    output logic               move_err,
    output logic               eng_clear,
    output logic               eng_move_valid,
    output logic [3:0]         eng_move_pos,
    input  logic [8:0]         eng_occupied,
    input  logic [1:0]         eng_player,
    input  logic [1:0]         eng_winner,
    input  logic               eng_draw,
    input  logic               new_match,
    output logic [SCORE_W-1:0] x_score,
    output logic [SCORE_W-1:0] o_score,
    output logic [1:0]         match_winner,
    output logic               timeout_pulse
);

    if (TURN_TIMEOUT < 1 || (2 ** SCORE_W) <= ROUNDS_TO_WIN) begin : g_param_check
        $error("ttt_match_controller: invalid TURN_TIMEOUT/ROUNDS_TO_WIN/SCORE_W");
    end

    typedef enum logic [2:0] {
        S_CLEAR,
        S_WAIT_MOVE,
        S_ISSUE,
        S_REJECT,
        S_SETTLE,
        S_CHECK,
        S_MATCH_OVER
    } state_t;

    localparam logic [1:0]         PL_X       = 2'd1;
    localparam logic [1:0]         PL_O       = 2'd2;
    localparam logic [SCORE_W-1:0] SCORE_LAST = SCORE_W'(ROUNDS_TO_WIN - 1);

    state_t       state;
    state_t       state_next;
    logic         settle_second;
    logic         x_armed;
    logic         o_armed;

    logic         cur_req;
    logic [3:0]   cur_pos;
    logic         cur_legal;
    logic [1:0]   grant_next;
    logic [3:0]   pos_next;
    logic         x_score_inc;
    logic         o_score_inc;
    logic         match_end;
    logic         auto_move;
    logic [3:0]   auto_pos;

    logic         eng_clear_d;
    logic         eng_move_valid_d;
    logic [3:0]   eng_move_pos_d;
    logic         x_ack_d;
    logic         o_ack_d;
    logic         move_err_d;

`ifdef TTT_TURN_TIMEOUT_EN
    localparam int TIMER_W = (TURN_TIMEOUT > 1) ? $clog2(TURN_TIMEOUT) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TURN_TIMEOUT - 1);

    logic [TIMER_W-1:0] turn_timer;
    logic               timeout_hit;
    logic [4:0]         free_cell;
    logic               timeout_pulse_d;

    // {found, index} of the lowest-numbered empty cell
    function automatic logic [4:0] lowest_free(input logic [8:0] occ);
        logic [4:0] r;
        r = 5'd0;
        for (int i = 8; i >= 0; i--) begin
            if (!occ[i]) r = {1'b1, 4'(i)};
        end
        return r;
    endfunction

    assign timeout_hit     = (turn_timer == TIMER_LAST);
    assign free_cell       = lowest_free(eng_occupied);
    assign auto_move       = timeout_hit && free_cell[4];
    assign auto_pos        = free_cell[3:0];
    assign timeout_pulse_d = (state_next == S_ISSUE) && (grant_next == 2'd0);

    // Timer saturates at the timeout value; restarted for every new turn and round.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            turn_timer <= '0;
        end else if (state == S_CLEAR || state == S_CHECK) begin
            turn_timer <= '0;
        end else if ((state == S_WAIT_MOVE || state == S_REJECT) && !timeout_hit) begin
            turn_timer <= turn_timer + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) timeout_pulse <= 1'b0;
        else       timeout_pulse <= timeout_pulse_d;
    end
`else
    assign auto_move     = 1'b0;
    assign auto_pos      = 4'd0;
    assign timeout_pulse = 1'b0;
`endif

    // Only the player whose turn the engine reports is looked at.
    always_comb begin
        cur_req = 1'b0;
        cur_pos = 4'd0;
        if (eng_player == PL_X) begin
            cur_req = x_req && x_armed;
            cur_pos = x_pos;
        end else if (eng_player == PL_O) begin
            cur_req = o_req && o_armed;
            cur_pos = o_pos;
        end
        cur_legal = (cur_pos <= 4'd8) && !(|(eng_occupied & (9'd1 << cur_pos)));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_CLEAR;
        else       state <= state_next;
    end

    always_comb begin
        state_next  = state;
        grant_next  = 2'd0;
        pos_next    = 4'd0;
        x_score_inc = 1'b0;
        o_score_inc = 1'b0;
        match_end   = 1'b0;
        case (state)
            S_CLEAR: state_next = S_WAIT_MOVE;
            S_WAIT_MOVE: begin
                if (cur_req && cur_legal) begin
                    grant_next = eng_player;
                    pos_next   = cur_pos;
                    state_next = S_ISSUE;
                end else if (auto_move) begin
                    pos_next   = auto_pos;
                    state_next = S_ISSUE;
                end else if (cur_req) begin
                    grant_next = eng_player;
                    state_next = S_REJECT;
                end
            end
            S_ISSUE:  state_next = S_SETTLE;
            S_REJECT: state_next = S_WAIT_MOVE;
            S_SETTLE: if (settle_second) state_next = S_CHECK;
            S_CHECK: begin
                x_score_inc = (eng_winner == PL_X);
                o_score_inc = (eng_winner == PL_O);
                if ((x_score_inc && x_score == SCORE_LAST) ||
                    (o_score_inc && o_score == SCORE_LAST)) begin
                    match_end  = 1'b1;
                    state_next = S_MATCH_OVER;
                end else if (x_score_inc || o_score_inc || eng_draw) begin
                    state_next = S_CLEAR;
                end else begin
                    state_next = S_WAIT_MOVE;
                end
            end
            S_MATCH_OVER: if (new_match) state_next = S_CLEAR;
            default:      state_next = S_CLEAR;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state they belong to.
    always_comb begin
        eng_clear_d      = (state_next == S_CLEAR);
        eng_move_valid_d = (state_next == S_ISSUE);
        eng_move_pos_d   = (state_next == S_ISSUE) ? pos_next : 4'd0;
        x_ack_d          = (state_next == S_ISSUE || state_next == S_REJECT) && (grant_next == PL_X);
        o_ack_d          = (state_next == S_ISSUE || state_next == S_REJECT) && (grant_next == PL_O);
        move_err_d       = (state_next == S_REJECT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            eng_clear      <= 1'b1;
            eng_move_valid <= 1'b0;
            eng_move_pos   <= 4'd0;
            x_ack          <= 1'b0;
            o_ack          <= 1'b0;
            move_err       <= 1'b0;
        end else begin
            eng_clear      <= eng_clear_d;
            eng_move_valid <= eng_move_valid_d;
            eng_move_pos   <= eng_move_pos_d;
            x_ack          <= x_ack_d;
            o_ack          <= o_ack_d;
            move_err       <= move_err_d;
        end
    end

    // A player is re-armed only once its request has been seen low after an ack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            settle_second <= 1'b0;
            x_armed       <= 1'b1;
            o_armed       <= 1'b1;
        end else begin
            settle_second <= (state == S_SETTLE) ? ~settle_second : 1'b0;
            if (state == S_CLEAR) x_armed <= 1'b1;
            else if (x_ack_d)     x_armed <= 1'b0;
            else if (!x_req)      x_armed <= 1'b1;
            if (state == S_CLEAR) o_armed <= 1'b1;
            else if (o_ack_d)     o_armed <= 1'b0;
            else if (!o_req)      o_armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_score      <= '0;
            o_score      <= '0;
            match_winner <= 2'd0;
        end else if (state == S_MATCH_OVER && new_match) begin
            x_score      <= '0;
            o_score      <= '0;
            match_winner <= 2'd0;
        end else begin
            if (x_score_inc) x_score <= x_score + 1'b1;
            if (o_score_inc) o_score <= o_score + 1'b1;
            if (match_end)   match_winner <= eng_winner;
        end
    end

endmodule

// File: tb/tb_ttt_match_controller.sv
// Randomized bench for ttt_match_controller with a reactive engine model and a round/score reference.
`timescale 1ns/1ps
module tb_ttt_match_controller;
    localparam int TT = 16;
    localparam int R  = 3;
    localparam int SW = 4;
    localparam int LINES [24] = '{0,1,2, 3,4,5, 6,7,8, 0,3,6, 1,4,7, 2,5,8, 0,4,8, 2,4,6};

    logic clk = 1'b0;
    logic reset;
    logic x_req, o_req, new_match;
    logic [3:0] x_pos, o_pos;
    logic x_ack, o_ack, move_err, eng_clear, eng_move_valid, timeout_pulse;
    logic [3:0] eng_move_pos;
    logic [8:0] eng_occupied;
    logic [1:0] eng_player, eng_winner, match_winner;
    logic eng_draw;
    logic [SW-1:0] x_score, o_score;

    int checks = 0;
    int failures = 0;
    int exp_x = 0, exp_o = 0, exp_mw = 0;

    logic [8:0][1:0] board;
    logic [1:0] turn;

    ttt_match_controller #(.TURN_TIMEOUT(TT), .ROUNDS_TO_WIN(R), .SCORE_W(SW)) dut (
        .clk(clk), .reset(reset),
        .x_req(x_req), .x_pos(x_pos), .x_ack(x_ack),
        .o_req(o_req), .o_pos(o_pos), .o_ack(o_ack),
        .move_err(move_err), .eng_clear(eng_clear),
        .eng_move_valid(eng_move_valid), .eng_move_pos(eng_move_pos),
        .eng_occupied(eng_occupied), .eng_player(eng_player),
        .eng_winner(eng_winner), .eng_draw(eng_draw),
        .new_match(new_match), .x_score(x_score), .o_score(o_score),
        .match_winner(match_winner), .timeout_pulse(timeout_pulse)
    );

    always #5 clk = ~clk;

    // Engine model: clears on strobe, places the current player's mark, alternates turns.
    always @(posedge clk) begin
        if (eng_clear) begin
            board <= '0;
            turn  <= 2'd1;
        end else if (eng_move_valid) begin
            if (eng_move_pos <= 4'd8) board[eng_move_pos] <= turn;
            turn <= (turn == 2'd1) ? 2'd2 : 2'd1;
        end
    end

    always_comb begin
        eng_player   = turn;
        eng_winner   = 2'd0;
        eng_occupied = '0;
        for (int i = 0; i < 9; i++) eng_occupied[i] = (board[i] != 2'd0);
        for (int l = 0; l < 8; l++) begin
            if (board[LINES[3*l]] != 2'd0 && board[LINES[3*l]] == board[LINES[3*l+1]] &&
                board[LINES[3*l]] == board[LINES[3*l+2]])
                eng_winner = board[LINES[3*l]];
        end
        eng_draw = (&eng_occupied) && (eng_winner == 2'd0);
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise the request, wait for the controller's response and compare it with the board rules.
    task automatic do_move(input int who, input int pos, input bit other, input bit hold,
                           output int lat, output bit accepted);
        bit got;
        bit legal;
        logic [3:0] p;
        p = 4'(pos);
        if (who == 1) begin
            x_req = 1'b1; x_pos = p;
            if (other) begin o_req = 1'b1; o_pos = 4'($urandom_range(0, 15)); end
        end else begin
            o_req = 1'b1; o_pos = p;
            if (other) begin x_req = 1'b1; x_pos = 4'($urandom_range(0, 15)); end
        end
        lat = 0;
        got = 1'b0;
        while (!got && lat < 12) begin
            tick();
            lat++;
            if (x_ack || o_ack || eng_move_valid) got = 1'b1;
        end
        legal = 1'b0;
        if (pos <= 8) legal = (board[pos] == 2'd0);
        chk("response_seen", got, 1);
        chk("x_ack", x_ack, who == 1);
        chk("o_ack", o_ack, who == 2);
        chk("move_err", move_err, !legal);
        chk("move_valid", eng_move_valid, legal);
        if (legal) chk("move_pos", eng_move_pos, p);
        if (!hold) begin x_req = 1'b0; o_req = 1'b0; end
        accepted = legal;
    endtask

    // Round/score reference: evaluated from the engine's state after the move lands.
    task automatic post_move();
        int clears;
        int exp_clears;
        logic [1:0] w;
        logic d;
        tick();
        w = eng_winner;
        d = eng_draw;
        clears = 0;
        repeat (5) begin
            tick();
            if (eng_clear) clears++;
        end
        if (w == 2'd1) exp_x++;
        if (w == 2'd2) exp_o++;
        if (w != 2'd0 && (exp_x == R || exp_o == R)) begin
            exp_mw = int'(w);
            exp_clears = 0;
        end else begin
            exp_clears = (w != 2'd0 || d) ? 1 : 0;
        end
        chk("clear_pulses", clears, exp_clears);
        chk("x_score", x_score, exp_x);
        chk("o_score", o_score, exp_o);
        chk("match_winner", match_winner, exp_mw);
    endtask

    task automatic play(input int who, input int pos);
        int lat;
        bit acc;
        do_move(who, pos, 1'b0, 1'b0, lat, acc);
        if (acc) post_move();
        else tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_clear", eng_clear, 1);
        chk("rst_x_ack", x_ack, 0);
        chk("rst_o_ack", o_ack, 0);
        chk("rst_move_valid", eng_move_valid, 0);
        chk("rst_timeout", timeout_pulse, 0);
        tick();
        reset = 1'b0;
        exp_x = 0; exp_o = 0; exp_mw = 0;
        chk("rst_scores", {x_score, o_score}, 0);
    endtask

    task automatic do_new_match();
        int clears;
        new_match = 1'b1;
        tick();
        new_match = 1'b0;
        clears = eng_clear ? 1 : 0;
        repeat (2) begin
            tick();
            if (eng_clear) clears++;
        end
        exp_x = 0; exp_o = 0; exp_mw = 0;
        chk("nm_clear_pulses", clears, 1);
        chk("nm_x_score", x_score, 0);
        chk("nm_o_score", o_score, 0);
        chk("nm_match_winner", match_winner, 0);
    endtask

    initial begin
        int lat, n, moves, acks, pos;
        bit acc, last_rej, found;
        int empties[$];
        reset = 1'b1;
        x_req = 1'b0; o_req = 1'b0; new_match = 1'b0;
        x_pos = 4'd0; o_pos = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_eng_clear", eng_clear, 1);
        chk("reset_acks", {x_ack, o_ack, move_err}, 0);
        chk("reset_move", {eng_move_valid, eng_move_pos}, 0);
        chk("reset_scores", {x_score, o_score, match_winner}, 0);
        chk("reset_timeout", timeout_pulse, 0);

        reset = 1'b0;
        do_move(1, 4, 1'b1, 1'b0, lat, acc);
        chk("startup_latency", lat, 2);
        do_move(2, 4, 1'b0, 1'b0, lat, acc);
        chk("accept_to_next_latency", lat, 5);
        tick();
        do_move(2, 0, 1'b0, 1'b0, lat, acc);
        chk("reject_to_next_latency", lat, 1);
        post_move();

        // X holds its request through a reject while O requests out of turn.
        do_move(1, 11, 1'b1, 1'b1, lat, acc);
        acks = 0;
        repeat (6) begin
            tick();
            if (x_ack || o_ack || eng_move_valid) acks++;
        end
        chk("no_regrant_while_held", acks, 0);
        x_req = 1'b0; o_req = 1'b0;
        tick();
        do_move(1, 8, 1'b0, 1'b0, lat, acc);
        chk("regrant_latency", lat, 1);
        do_reset();

        play(1, 0); play(2, 3); play(1, 1); play(2, 4); play(1, 2);
        play(1, 0); play(2, 1); play(1, 2); play(2, 4); play(1, 3);
        play(2, 5); play(1, 7); play(2, 6); play(1, 8);
        for (int r = 0; r < 2; r++) begin
            play(1, 0); play(2, 3); play(1, 1); play(2, 4); play(1, 2);
        end
        chk("match_over_winner", match_winner, 1);
        x_req = 1'b1; x_pos = 4'd0; o_req = 1'b1; o_pos = 4'd1;
        acks = 0;
        repeat (8) begin
            tick();
            if (x_ack || o_ack || eng_move_valid || eng_clear) acks++;
        end
        chk("match_over_ignores", acks, 0);
        x_req = 1'b0; o_req = 1'b0;
        tick();
        do_new_match();

        moves = 0;
        last_rej = 1'b0;
        while (exp_mw == 0 && moves < 400) begin
            moves++;
            if (last_rej) begin
                empties.delete();
                for (int i = 0; i < 9; i++) if (board[i] == 2'd0) empties.push_back(i);
                pos = empties[$urandom_range(0, empties.size() - 1)];
            end else begin
                pos = int'($urandom_range(0, 11));
            end
            do_move(int'(eng_player), pos, ($urandom_range(0, 3) == 0), 1'b0, lat, acc);
            chk("random_latency", lat, 1);
            if (acc) post_move();
            else tick();
            last_rej = !acc;
        end
        chk("random_match_finished", exp_mw != 0, 1);
        if (exp_mw != 0) do_new_match();
        else do_reset();

        play(1, 0);
        do_move(2, 1, 1'b0, 1'b0, lat, acc);
        n = 0;
        found = 1'b0;
        while (!found && n < 40) begin
            tick();
            n++;
            if (eng_move_valid || timeout_pulse || x_ack || o_ack) found = 1'b1;
        end
`ifdef TTT_TURN_TIMEOUT_EN
        chk("timeout_seen", found, 1);
        chk("timeout_latency", n, 20);
        chk("timeout_pulse", timeout_pulse, 1);
        chk("timeout_move_valid", eng_move_valid, 1);
        chk("timeout_pos", eng_move_pos, 2);
        chk("timeout_no_ack", {x_ack, o_ack}, 0);
`else
        chk("no_auto_move", found, 0);
        chk("no_timeout_pulse", timeout_pulse, 0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "bench time limit");
    end

endmodule

// File: doc/ttt_match_controller.md
# ttt_match_controller

Sequencer and arbiter in front of the tic-tac-toe board engine. It owns the engine's move port and shares it between two player requesters (X and O), grants only the player whose turn it is, and rejects illegal moves before they reach the engine. It clears the engine between rounds and keeps a best-of-N match score. An optional turn timer auto-plays for a stalled player.

## Interface
Parameters:
- `TURN_TIMEOUT`, default 1000: cycles a player has to move before an auto-move.
- `ROUNDS_TO_WIN`, default 3: round wins that end the match.
- `SCORE_W`, default 4: score counter width. Must satisfy 2^SCORE_W > ROUNDS_TO_WIN.

Ports:
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high.
- `x_req` in 1: player X move request (level).
- `x_pos` in 4: X cell index, 0–8.
- `x_ack` out 1: one-cycle X accept/reject pulse.
- `o_req` in 1: player O move request (level).
- `o_pos` in 4: O cell index, 0–8.
- `o_ack` out 1: one-cycle O accept/reject pulse.
- `move_err` out 1: pulses with ack when a move is rejected.
- `eng_clear` out 1: engine reset strobe.
- `eng_move_valid` out 1: one-cycle move strobe to the engine.
- `eng_move_pos` out 4: cell index for the move.
- `eng_occupied` in 9: bit i set when engine cell i is non-empty.
- `eng_player` in 2: engine current player; 1 = X, 2 = O.
- `eng_winner` in 2: engine winner; 0 = none, 1 = X, 2 = O.
- `eng_draw` in 1: engine draw flag.
- `new_match` in 1: restarts the match from MATCH_OVER.
- `x_score` out SCORE_W: X round wins.
- `o_score` out SCORE_W: O round wins.
- `match_winner` out 2: 0 while the match is open, else 1 = X or 2 = O.
- `timeout_pulse` out 1: pulses when an auto-move is issued.

## Operation
- FSM states: CLEAR, WAIT_MOVE, ISSUE, REJECT, SETTLE, CHECK, MATCH_OVER.
- All outputs are registered and decoded from state.
- **CLEAR** (1 cycle): `eng_clear`=1; turn timer zeroed; next state WAIT_MOVE.
- **WAIT_MOVE**: only the requester matching `eng_player` is sampled. The other player's `req` is ignored and gets no ack.
  - Legal move (pos ≤ 8 and `eng_occupied[pos]`=0): latch pos, go to ISSUE.
  - Pos > 8 or cell occupied: go to REJECT.
- **Re-arm rule**: after an ack, a player's `req` must be sampled low at least once before that player is granted again. This is tracked by a per-player armed flag, which is set at reset and on CLEAR.
- **ISSUE** (1 cycle): `eng_move_valid`=1, `eng_move_pos`=latched pos, ack of the granted player =1; next state SETTLE.
- **REJECT** (1 cycle): ack=1 and `move_err`=1; next state WAIT_MOVE. The turn timer keeps running.
- **SETTLE** (2 cycles): waits for the engine flags to settle; next state CHECK.
- **CHECK** (1 cycle):
  - `eng_winner`≠0: increment that player's score.
  - Then, if `eng_winner`≠0 or `eng_draw`=1: if the new score equals ROUNDS_TO_WIN, set `match_winner` and go to MATCH_OVER; otherwise go to CLEAR.
  - Otherwise: go to WAIT_MOVE with the turn timer zeroed.
- A draw never changes a score.
- **MATCH_OVER**: holds the scores and `match_winner`; all requests are ignored. A `new_match`=1 zeroes the scores and `match_winner` and goes to CLEAR.
- Scores never exceed ROUNDS_TO_WIN; no wrap is possible.

## Timing
- **Reset values**: state CLEAR; every output 0 except `eng_clear`=1 during the CLEAR cycle; scores 0; both armed flags set.
- **Start-up**: the first legal request can be sampled 2 cycles after `reset` deasserts.
- **Accepted move**: req sampled at edge N → ack and `eng_move_valid` at N+1 → CHECK at N+4 → WAIT_MOVE at N+5. Minimum 5 cycles per move.
- **Rejected move**: ack and `move_err` at N+1 → back in WAIT_MOVE at N+2.
- **Simultaneous `x_req` and `o_req`**: only the current player is served.
- **Reset mid-operation**: immediate return to reset values from any state, including ISSUE. A pending ack is lost.

## Configuration
- **`TTT_TURN_TIMEOUT_EN` defined**: the turn timer counts every cycle in WAIT_MOVE and REJECT. When it reaches TURN_TIMEOUT-1, the controller auto-moves to the lowest-index empty cell: it enters ISSUE with `timeout_pulse`=1 and no player ack. A legal request in the same cycle as the timeout wins over the auto-move. The timer is TURN_TIMEOUT-sized.
- **Undefined**: no timer logic is built; `timeout_pulse` is tied to 0; the controller waits indefinitely.

## Test plan
- **Legal move**: reset, then X req pos 4 → `x_ack` and `eng_move_valid` together with `eng_move_pos`=4; `o_ack` stays 0.
- **Occupied cell**: O req pos 4 while `eng_occupied[4]`=1 → `o_ack`=1 and `move_err`=1, no `eng_move_valid`. O then requests pos 0 → accepted.
- **Out of turn and re-arm**: X holds `x_req` high through its ack → no second grant until `x_req` drops. `o_req` while it is X's turn → ignored.
- **Round win**: engine model reports `eng_winner`=1 at CHECK → `x_score`=1 and a single `eng_clear` pulse. A draw → scores unchanged, `eng_clear` pulse.
- **Match end**: X wins 3 rounds → `match_winner`=1, MATCH_OVER, requests ignored. `new_match` → scores 0, `eng_clear` pulse.
- **Timeout (macro on, TURN_TIMEOUT=16)**: no requests for 16 cycles with `eng_occupied`=9'b000000011 → `timeout_pulse` and `eng_move_valid` with pos 2. With the macro off, no move ever issues.
